// File: rtl/pc_stack.sv
// Program counter plus circular return-address stack for the TB4004 core.
// One PC action per machine cycle; addr_nib muxes PC nibbles onto A1..A3.
module pc_stack #(
    parameter int ADDR_W    = 12,
    parameter int DEPTH     = 3,
    parameter int INC_CYCLE = 2,
    localparam int SP_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        cycle,
    input  logic              pc_load,
    input  logic              pc_load_pg,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] pc_new,
    input  logic              flag_clr,
    output logic [ADDR_W-1:0] pc_addr,
    output logic [3:0]        addr_nib,
    output logic [SP_W-1:0]   sp,
    output logic [3:0]        level,
    output logic              ovf,
    output logic              unf
);

    localparam int NIBS = ADDR_W / 4;
    localparam logic [SP_W-1:0] SP_LAST   = SP_W'(DEPTH - 1);
    localparam logic [3:0]      LEVEL_MAX = 4'(DEPTH);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] stk [DEPTH];
    logic [SP_W-1:0]   sp_inc;
    logic [SP_W-1:0]   sp_dec;
    logic [ADDR_W-1:0] pc_pg;
    logic              set_ovf;
    logic              set_unf;

    assign sp_inc  = (sp == SP_LAST) ? '0 : sp + SP_W'(1);
    assign sp_dec  = (sp == '0) ? SP_LAST : sp - SP_W'(1);
    assign set_ovf = push && !pop && (level == LEVEL_MAX);
    assign set_unf = pop && (level == 4'd0);

    // Page-local load keeps everything above bit 7; written this way so ADDR_W=8 works.
    always_comb begin
        pc_pg      = pc;
        pc_pg[7:0] = pc_new[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= '0;
            sp    <= '0;
            level <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stk[i] <= '0;
            end
        end else begin
            if (pop) begin
                sp <= sp_dec;
                pc <= stk[sp_dec];
                if (level != 4'd0) begin
                    level <= level - 4'd1;
                end
            end else if (push) begin
                // A full stack wraps and overwrites its oldest entry, as on the 4004.
                stk[sp] <= pc;
                pc      <= pc_new;
                sp      <= sp_inc;
                if (level != LEVEL_MAX) begin
                    level <= level + 4'd1;
                end
            end else if (pc_load) begin
                pc <= pc_new;
            end else if (pc_load_pg) begin
                pc <= pc_pg;
            end else if (cycle == 3'(INC_CYCLE)) begin
                pc <= pc + ADDR_W'(1);
            end

            ovf <= set_ovf || (ovf && !flag_clr);
            unf <= set_unf || (unf && !flag_clr);
        end
    end

    always_comb begin
        addr_nib = 4'h0;
        for (int k = 0; k < NIBS; k++) begin
            if (int'(cycle) == k) begin
                addr_nib = pc[4*k +: 4];
            end
        end
    end

    assign pc_addr = pc;

endmodule

// File: doc/pc_stack.md
# pc_stack

Parametrised program-counter and return-address stack for the TB4004 core. It holds the active PC plus a DEPTH-level circular stack of return addresses, supporting full loads (JUN/JIN), page-local loads (JCN/ISZ/FIN), subroutine call (JMS) and return (BBL). The block advances once per machine cycle and drives the 4-bit address nibble for A1..A3. It sits between the instruction decoder (control strobes) and the external address/data bus mux.

## Interface
- ADDR_W, 12, PC/stack width in bits; multiple of 4, range 8..32.
- DEPTH, 3, number of return-address stack entries; range 1..8.
- INC_CYCLE, 2, cycle index at which PC increments (default A3).
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cycle  in  3  machine-cycle index, 0..7 = A1,A2,A3,M1,M2,X1,X2,X3.
- pc_load  in  1  load PC with pc_new.
- pc_load_pg  in  1  page-local load: PC[7:0] <= pc_new[7:0], upper bits kept.
- push  in  1  call: push current PC, then PC <= pc_new.
- pop  in  1  return: PC <= top of stack, pop.
- pc_new  in  ADDR_W  target address.
- flag_clr  in  1  clear sticky ovf/unf flags.
- pc_addr  out  ADDR_W  current PC.
- addr_nib  out  4  nibble for address bus, selected by cycle.
- sp  out  $clog2(DEPTH) (min 1)  stack write pointer.
- level  out  4  occupied entries, 0..DEPTH, saturating.
- ovf  out  1  sticky: push while level==DEPTH.
- unf  out  1  sticky: pop while level==0.

## Operation
- State: pc (ADDR_W), stk[0..DEPTH-1] (ADDR_W each), sp, level, ovf, unf.
- Per rising edge, exactly one PC action, priority pop > push > pc_load > pc_load_pg > increment.
- pop: sp <= (sp-1) mod DEPTH; pc <= stk[(sp-1) mod DEPTH]; level <= level-1 if level>0; if level==0 set unf (pop still performed, returns stale entry).
- push: stk[sp] <= pc (pre-update value); pc <= pc_new; sp <= (sp+1) mod DEPTH; level <= level+1 if level<DEPTH, else set ovf (oldest entry overwritten, circular as on 4004).
- pc_load: pc <= pc_new; stack untouched.
- pc_load_pg: pc <= {pc[ADDR_W-1:8], pc_new[7:0]}.
- increment: when no strobe active and cycle==INC_CYCLE, pc <= pc+1 mod 2^ADDR_W (wraps all-ones to 0).
- Strobes are honoured in any cycle, not only INC_CYCLE; a strobe in INC_CYCLE suppresses that increment.
- push and pop together: pop wins, push fully ignored (no stack write).
- flag_clr: ovf <= 0, unf <= 0; a set condition in the same edge wins (flag stays 1).
- addr_nib combinational: nibble index k = cycle; if k < ADDR_W/4 output pc[4k+3:4k], else 4'h0. ADDR_W=12: A1 low, A2 mid, A3 high, others 0.
- pc_addr, sp, level, ovf, unf are direct register outputs.

## Timing
- Reset (rst_n low, asynchronous): pc=0, all stk=0, sp=0, level=0, ovf=0, unf=0; hence pc_addr=0, addr_nib=0 in every cycle.
- Release of rst_n takes effect on the next rising edge; strobes on that edge are honoured.
- All updates: 1-cycle latency; new pc visible on pc_addr and addr_nib immediately after the edge.
- addr_nib has zero latency from cycle and pc.
- Strobes are single-cycle levels sampled on the edge; held high they re-apply every edge (held push pushes each cycle).
- Reset mid-operation (e.g. during a push edge) discards the operation; all state returns to reset values.

## Test plan
- Reset then 8 cycles with cycle 0..7, no strobes -> pc_addr 0 -> 1 after cycle 2 edge; addr_nib 0 throughout A1..A3 of first cycle set.
- pc_load 12'hFFF, run one cycle sequence -> increment at cycle 2 wraps to 12'h000; cycle 2 with pc_load 12'h123 -> pc=12'h123, no increment.
- pc=12'hAB5, pc_load_pg pc_new=12'h3C7 -> pc=12'hAC7; addr_nib at cycles 0/1/2 = 7/C/A.
- DEPTH=3: from pc 12'h010 push to 12'h100, 12'h200, 12'h300 -> level=3, ovf=0; pop x3 -> pc 12'h200, 12'h100, 12'h010, level 0, unf=0.
- DEPTH=3: four pushes (pc values 1,2,3,4 saved) -> ovf=1, level=3, entry 1 lost; four pops -> returns 4,3,2,4 (circular stale), unf=1; flag_clr -> both 0.
- push and pop same edge with level=1, top=12'h050 -> pc=12'h050, level 0, no stack write; rst_n pulse mid-sequence -> pc=0, sp=0, level=0, flags 0.
